// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-slot ALU issue scheduler.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit positions inside the one-hot ALU control word
    localparam int ADD = 0;
    localparam int SUB = 3;
    localparam int MUL = 4;
    localparam int CMP = 5;
    localparam int OR  = 7;
    localparam int AND = 8;
    localparam int LSL = 10;
    localparam int LSR = 11;

    localparam int DEF_MUL_CYCLES = 3;
    localparam int DEF_ALU_LAT    = 1;

    localparam int CTL_W  = 12;
    localparam int DATA_W = 16;
    localparam int IMM_W  = 5;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant: the pointer only matters when both slots request.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = rr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_issue_sched.sv
// Arbitrates two issue slots onto one shared multi-cycle ALU and returns
// each result through a valid/ready handshake tagged with its slot.
module alu_issue_sched
    import alu_sched_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int ALU_LAT    = DEF_ALU_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*CTL_W-1:0]    req_alusignals,
    input  logic [2*DATA_W-1:0]   req_op1,
    input  logic [2*DATA_W-1:0]   req_op2,
    input  logic [2*IMM_W-1:0]    req_immx,
    input  logic [1:0]            req_isimmediate,
    input  logic [2*DATA_W-1:0]   req_instr,
    output logic [CTL_W-1:0]      alu_alusignals,
    output logic [DATA_W-1:0]     alu_op1,
    output logic [DATA_W-1:0]     alu_op2,
    output logic [DATA_W-1:0]     alu_instr,
    output logic [IMM_W-1:0]      alu_immx,
    output logic                  alu_isimmediate,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     alu_instrout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_W-1:0]     res_data,
    output logic [DATA_W-1:0]     res_instr,
    output logic                  res_slot,
    output logic                  busy
);

    localparam int LAT_MAX = (MUL_CYCLES > ALU_LAT) ? MUL_CYCLES : ALU_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    state_e              state_q, state_d;
    logic                rr_q, rr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                launch_q, launch_d;
    logic [CTL_W-1:0]    ctl_q, ctl_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [IMM_W-1:0]    immx_q, immx_d;
    logic                isimm_q, isimm_d;
    logic                slot_q, slot_d;
    logic                res_valid_q, res_valid_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [DATA_W-1:0]   res_instr_q, res_instr_d;
    logic                res_slot_q, res_slot_d;

    logic [1:0]          grant;
    logic                can_accept;
    logic                accept;
    logic                gslot;
    logic [CTL_W-1:0]    sel_ctl;

    rr_arbiter2 u_arb (
        .req   (req_valid),
        .rr    (rr_q),
        .grant (grant)
    );

    assign can_accept = (state_q == IDLE) || ((state_q == DONE) && res_ready);
    assign req_ready  = (rst_n && can_accept) ? grant : 2'b00;
    assign accept     = |req_ready;
    assign gslot      = grant[1];
    assign sel_ctl    = gslot ? req_alusignals[2*CTL_W-1:CTL_W] : req_alusignals[CTL_W-1:0];

    // launch_q marks the first EXEC cycle, in which the ALU only receives
    // its operands; the latency countdown starts on the following cycle.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        launch_d    = launch_q;
        ctl_d       = ctl_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        instr_d     = instr_q;
        immx_d      = immx_q;
        isimm_d     = isimm_q;
        slot_d      = slot_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_instr_d = res_instr_q;
        res_slot_d  = res_slot_q;

        case (state_q)
            IDLE: ;
            EXEC: begin
                if (launch_q) begin
                    launch_d = 1'b0;
                end else if (cnt_q == '0) begin
                    res_data_d  = alu_result;
                    res_instr_d = alu_instrout;
                    res_slot_d  = slot_q;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d  = EXEC;
            rr_d     = ~gslot;
            slot_d   = gslot;
            launch_d = 1'b1;
            ctl_d    = sel_ctl;
            op1_d    = gslot ? req_op1[2*DATA_W-1:DATA_W]   : req_op1[DATA_W-1:0];
            op2_d    = gslot ? req_op2[2*DATA_W-1:DATA_W]   : req_op2[DATA_W-1:0];
            instr_d  = gslot ? req_instr[2*DATA_W-1:DATA_W] : req_instr[DATA_W-1:0];
            immx_d   = gslot ? req_immx[2*IMM_W-1:IMM_W]    : req_immx[IMM_W-1:0];
            isimm_d  = req_isimmediate[gslot];
            cnt_d    = sel_ctl[MUL] ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(ALU_LAT - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            cnt_q       <= '0;
            launch_q    <= 1'b0;
            ctl_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            instr_q     <= '0;
            immx_q      <= '0;
            isimm_q     <= 1'b0;
            slot_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_instr_q <= '0;
            res_slot_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            launch_q    <= launch_d;
            ctl_q       <= ctl_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            instr_q     <= instr_d;
            immx_q      <= immx_d;
            isimm_q     <= isimm_d;
            slot_q      <= slot_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_instr_q <= res_instr_d;
            res_slot_q  <= res_slot_d;
        end
    end

    assign alu_alusignals  = (state_q == EXEC) ? ctl_q : '0;
    assign alu_op1         = op1_q;
    assign alu_op2         = op2_q;
    assign alu_instr       = instr_q;
    assign alu_immx        = immx_q;
    assign alu_isimmediate = isimm_q;
    assign res_valid       = res_valid_q;
    assign res_data        = res_data_q;
    assign res_instr       = res_instr_q;
    assign res_slot        = res_slot_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_sched.sv
// Self-checking bench: directed scenarios plus a randomized run scored
// against a transaction-level model of the scheduler.
module tb_alu_issue_sched;

    localparam int MULC = 3;
    localparam int ALUL = 1;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [23:0] req_alusignals;
    logic [31:0] req_op1, req_op2, req_instr;
    logic [9:0]  req_immx;
    logic [1:0]  req_isimmediate;
    logic [11:0] alu_alusignals;
    logic [15:0] alu_op1, alu_op2, alu_instr;
    logic [4:0]  alu_immx;
    logic        alu_isimmediate;
    logic [15:0] alu_result, alu_instrout;
    logic        res_valid, res_ready;
    logic [15:0] res_data, res_instr;
    logic        res_slot, busy;

    int passed = 0;
    int total  = 0;

    logic [15:0] pipe_res [MULC];
    logic [15:0] pipe_ins [MULC];

    alu_issue_sched #(.MUL_CYCLES(MULC), .ALU_LAT(ALUL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alusignals(req_alusignals), .req_op1(req_op1), .req_op2(req_op2),
        .req_immx(req_immx), .req_isimmediate(req_isimmediate), .req_instr(req_instr),
        .alu_alusignals(alu_alusignals), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_instr(alu_instr), .alu_immx(alu_immx), .alu_isimmediate(alu_isimmediate),
        .alu_result(alu_result), .alu_instrout(alu_instrout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_instr(res_instr), .res_slot(res_slot), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [11:0] c, input logic [15:0] a,
                                           input logic [15:0] b, input logic [4:0] im,
                                           input logic isi);
        logic [15:0] y;
        logic [31:0] p;
        y = isi ? {11'b0, im} : b;
        p = a * y;
        if (c[0])  return a + y;
        if (c[3])  return a - y;
        if (c[4])  return p[15:0];
        if (c[5])  return (a < y) ? 16'd1 : 16'd0;
        if (c[7])  return a | y;
        if (c[8])  return a & y;
        if (c[10]) return a << y[3:0];
        if (c[11]) return a >> y[3:0];
        return 16'h0000;
    endfunction

    // Shared ALU: result appears ALU_LAT or MUL_CYCLES cycles after the control word
    always @(posedge clk) begin
        pipe_res[0] <= alu_fn(alu_alusignals, alu_op1, alu_op2, alu_immx, alu_isimmediate);
        pipe_ins[0] <= alu_instr;
        for (int i = 1; i < MULC; i++) begin
            pipe_res[i] <= pipe_res[i-1];
            pipe_ins[i] <= pipe_ins[i-1];
        end
    end
    assign alu_result   = alu_alusignals[4] ? pipe_res[MULC-1] : pipe_res[ALUL-1];
    assign alu_instrout = alu_alusignals[4] ? pipe_ins[MULC-1] : pipe_ins[ALUL-1];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_slot(input int s, input logic [11:0] c, input logic [15:0] a,
                            input logic [15:0] b, input logic [4:0] im, input logic isi,
                            input logic [15:0] ins);
        req_alusignals[s*12 +: 12] = c;
        req_op1[s*16 +: 16]        = a;
        req_op2[s*16 +: 16]        = b;
        req_immx[s*5 +: 5]         = im;
        req_isimmediate[s]         = isi;
        req_instr[s*16 +: 16]      = ins;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts cycles from an acceptance edge until res_valid is seen; 99 on timeout
    task automatic wait_result(output int n);
        n = 0;
        @(negedge clk); #1;
        while (!res_valid && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        if (!res_valid) n = 99;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        res_ready = 1'b1;
        set_slot(0, 12'h001, 16'h1111, 16'h2222, 5'd3, 1'b1, 16'h3333);
        set_slot(1, 12'h010, 16'h4444, 16'h5555, 5'd7, 1'b1, 16'h6666);
        repeat (2) @(negedge clk);
        #1;
        total++; if (req_ready !== 2'b00) $display("[TB] FAIL rst_req_ready: got %b want 00", req_ready); else passed++;
        total++; if (res_valid !== 1'b0) $display("[TB] FAIL rst_res_valid: got %b want 0", res_valid); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if ({res_data, res_instr, res_slot} !== 33'd0) $display("[TB] FAIL rst_res_fields: got %h/%h/%b want 0", res_data, res_instr, res_slot); else passed++;
        total++; if ({alu_alusignals, alu_op1, alu_op2, alu_instr, alu_immx, alu_isimmediate} !== 66'd0)
            $display("[TB] FAIL rst_alu_outs: got %h %h %h %h %h %b want 0", alu_alusignals, alu_op1, alu_op2, alu_instr, alu_immx, alu_isimmediate); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) $display("[TB] FAIL rst_first_grant: got %b want 01", req_ready); else passed++;
        req_valid = 2'b00;
        set_slot(0, 12'h000, 16'h0, 16'h0, 5'd0, 1'b0, 16'h0);
        set_slot(1, 12'h000, 16'h0, 16'h0, 5'd0, 1'b0, 16'h0);
    endtask

    task automatic test_add();
        int n;
        @(negedge clk);
        set_slot(0, 12'h001, 16'h0005, 16'h0003, 5'd0, 1'b0, 16'hA5A5);
        req_valid = 2'b01;
        res_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) $display("[TB] FAIL add_grant: got %b want 01", req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        total++; if (alu_alusignals !== 12'h001 || alu_op1 !== 16'h0005 || alu_op2 !== 16'h0003)
            $display("[TB] FAIL add_alu_drive: got %h %h %h want 001 0005 0003", alu_alusignals, alu_op1, alu_op2); else passed++;
        total++; if (busy !== 1'b1) $display("[TB] FAIL add_busy: got %b want 1", busy); else passed++;
        wait_result(n);
        total++; if (n != ALUL + 1) $display("[TB] FAIL add_latency: got %0d want %0d", n, ALUL + 1); else passed++;
        total++; if (res_data !== 16'h0008 || res_slot !== 1'b0 || res_instr !== 16'hA5A5)
            $display("[TB] FAIL add_result: got %h/%b/%h want 0008/0/a5a5", res_data, res_slot, res_instr); else passed++;
        total++; if (alu_alusignals !== 12'h000) $display("[TB] FAIL add_done_ctl: got %h want 000", alu_alusignals); else passed++;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || res_valid !== 1'b0) $display("[TB] FAIL add_to_idle: got busy=%b valid=%b want 0 0", busy, res_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        set_slot(0, 12'h001, 16'h0001, 16'h0002, 5'd0, 1'b0, 16'hA000);
        set_slot(1, 12'h008, 16'h000A, 16'h0004, 5'd0, 1'b0, 16'hB001);
        req_valid = 2'b11;
        res_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) $display("[TB] FAIL b2b_grant0: got %b want 01", req_ready); else passed++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            wait_result(n);
            total++; if (n != ALUL + 1) $display("[TB] FAIL b2b_latency%0d: got %0d want %0d", k, n, ALUL + 1); else passed++;
            total++; if (res_slot !== k[0]) $display("[TB] FAIL b2b_slot%0d: got %b want %b", k, res_slot, k[0]); else passed++;
            total++; if (res_data !== (k[0] ? 16'h0006 : 16'h0003)) $display("[TB] FAIL b2b_data%0d: got %h want %h", k, res_data, k[0] ? 16'h0006 : 16'h0003); else passed++;
            total++; if (res_instr !== (k[0] ? 16'hB001 : 16'hA000)) $display("[TB] FAIL b2b_instr%0d: got %h", k, res_instr); else passed++;
            total++; if (req_ready !== (k[0] ? 2'b01 : 2'b10)) $display("[TB] FAIL b2b_rearm%0d: got %b want %b", k, req_ready, k[0] ? 2'b01 : 2'b10); else passed++;
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) $display("[TB] FAIL b2b_idle: got %b want 0", busy); else passed++;
    endtask

    task automatic test_mul();
        int n;
        @(negedge clk);
        set_slot(1, 12'h010, 16'h0005, 16'h0003, 5'd0, 1'b0, 16'hC0DE);
        req_valid = 2'b10;
        res_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b10) $display("[TB] FAIL mul_grant: got %b want 10", req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_result(n);
        total++; if (n != MULC + 1) $display("[TB] FAIL mul_latency: got %0d want %0d", n, MULC + 1); else passed++;
        total++; if (res_data !== 16'h000F || res_slot !== 1'b1 || res_instr !== 16'hC0DE)
            $display("[TB] FAIL mul_result: got %h/%b/%h want 000f/1/c0de", res_data, res_slot, res_instr); else passed++;
        @(posedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        set_slot(0, 12'h080, 16'h00F0, 16'h000F, 5'd0, 1'b0, 16'h1234);
        req_valid = 2'b01;
        res_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_result(n);
        total++; if (n != ALUL + 1) $display("[TB] FAIL bp_latency: got %0d want %0d", n, ALUL + 1); else passed++;
        set_slot(1, 12'h100, 16'hFF0F, 16'h0FF0, 5'd0, 1'b0, 16'h5678);
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            total++; if (res_valid !== 1'b1 || res_data !== 16'h00FF || res_instr !== 16'h1234)
                $display("[TB] FAIL bp_hold%0d: got %b/%h/%h want 1/00ff/1234", k, res_valid, res_data, res_instr); else passed++;
            total++; if (req_ready !== 2'b00 || busy !== 1'b1)
                $display("[TB] FAIL bp_stall%0d: got ready=%b busy=%b want 00 1", k, req_ready, busy); else passed++;
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b10) $display("[TB] FAIL bp_release_grant: got %b want 10", req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        total++; if (res_valid !== 1'b0 || busy !== 1'b1 || alu_alusignals !== 12'h100)
            $display("[TB] FAIL bp_exec_entry: got %b/%b/%h want 0/1/100", res_valid, busy, alu_alusignals); else passed++;
        wait_result(n);
        total++; if (n != ALUL + 1 || res_data !== 16'h0F00 || res_slot !== 1'b1)
            $display("[TB] FAIL bp_second: got n=%0d %h/%b want %0d 0f00/1", n, res_data, res_slot, ALUL + 1); else passed++;
        @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        set_slot(0, 12'h010, 16'h0007, 16'h0009, 5'd0, 1'b0, 16'h0BAD);
        req_valid = 2'b01;
        res_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #3;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #1;
        total++; if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00)
            $display("[TB] FAIL rmid_ctrl: got %b/%b/%b want 0/0/00", res_valid, busy, req_ready); else passed++;
        total++; if ({res_data, res_instr, res_slot} !== 33'd0) $display("[TB] FAIL rmid_res: got %h/%h/%b want 0", res_data, res_instr, res_slot); else passed++;
        total++; if ({alu_alusignals, alu_op1, alu_op2, alu_instr, alu_immx, alu_isimmediate} !== 66'd0)
            $display("[TB] FAIL rmid_alu: got %h %h %h %h want 0", alu_alusignals, alu_op1, alu_op2, alu_instr); else passed++;
        repeat (2) @(negedge clk);
        set_slot(1, 12'h001, 16'h0001, 16'h0001, 5'd0, 1'b0, 16'h0002);
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01 || res_valid !== 1'b0) $display("[TB] FAIL rmid_regrant: got %b/%b want 01/0", req_ready, res_valid); else passed++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_result(n);
        total++; if (n != MULC + 1 || res_data !== 16'd63 || res_slot !== 1'b0)
            $display("[TB] FAIL rmid_result: got n=%0d %h/%b want %0d 003f/0", n, res_data, res_slot, MULC + 1); else passed++;
        @(posedge clk);
    endtask

    task automatic test_immediate();
        int n;
        @(negedge clk);
        set_slot(0, 12'h001, 16'h0004, 16'h7777, 5'b00010, 1'b1, 16'h0101);
        req_valid = 2'b01;
        res_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        total++; if (alu_isimmediate !== 1'b1 || alu_immx !== 5'd2) $display("[TB] FAIL imm_drive: got %b/%0d want 1/2", alu_isimmediate, alu_immx); else passed++;
        wait_result(n);
        total++; if (res_data !== 16'h0006) $display("[TB] FAIL imm_result: got %h want 0006", res_data); else passed++;
        @(posedge clk);
        set_slot(0, 12'h000, 16'h0, 16'h0, 5'd0, 1'b0, 16'h0);
    endtask

    // Reference: a pending op finishes (ALU_LAT or MUL_CYCLES)+1 edges after
    // acceptance and its result is held until taken.
    task automatic test_random();
        logic [11:0] ctl_tbl [9];
        logic [11:0] f_ctl [2];
        logic [15:0] f_a [2], f_b [2], f_ins [2];
        logic [4:0]  f_im [2];
        logic        f_isi [2];
        logic [1:0]  v, exp_g;
        int          m_phase, m_remain;
        logic        m_rr, m_rs, can;
        logic [11:0] m_ctl;
        logic [15:0] m_rd, m_ri;
        int          s;
        ctl_tbl = '{12'h001, 12'h008, 12'h010, 12'h020, 12'h080, 12'h100, 12'h400, 12'h800, 12'h000};
        do_reset();
        m_phase = 0; m_remain = 0; m_rr = 1'b0; m_rs = 1'b0;
        m_ctl = '0; m_rd = '0; m_ri = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc != 0) @(negedge clk);
            v = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                f_ctl[k] = ctl_tbl[$urandom_range(0, 8)];
                f_a[k]   = 16'($urandom);
                f_b[k]   = 16'($urandom);
                f_im[k]  = 5'($urandom);
                f_isi[k] = 1'($urandom);
                f_ins[k] = 16'($urandom);
                set_slot(k, f_ctl[k], f_a[k], f_b[k], f_im[k], f_isi[k], f_ins[k]);
            end
            req_valid = v;
            res_ready = ($urandom_range(0, 9) < 7);
            #1;
            can   = (m_phase == 0) || (m_phase == 2 && res_ready);
            exp_g = 2'b00;
            if (can) exp_g = (v == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : v;
            total++; if (req_ready !== exp_g) $display("[TB] FAIL rnd_ready@%0d: got %b want %b", cyc, req_ready, exp_g); else passed++;
            total++; if (busy !== (m_phase != 0) || res_valid !== (m_phase == 2))
                $display("[TB] FAIL rnd_status@%0d: got busy=%b valid=%b want phase %0d", cyc, busy, res_valid, m_phase); else passed++;
            total++; if (alu_alusignals !== ((m_phase == 1) ? m_ctl : 12'h000))
                $display("[TB] FAIL rnd_ctl@%0d: got %h want %h", cyc, alu_alusignals, (m_phase == 1) ? m_ctl : 12'h000); else passed++;
            if (m_phase == 2) begin
                total++; if (res_data !== m_rd || res_instr !== m_ri || res_slot !== m_rs)
                    $display("[TB] FAIL rnd_result@%0d: got %h/%h/%b want %h/%h/%b", cyc, res_data, res_instr, res_slot, m_rd, m_ri, m_rs); else passed++;
            end
            @(posedge clk);
            if (m_phase == 1) begin
                m_remain--;
                if (m_remain == 0) m_phase = 2;
            end else if (m_phase == 2 && res_ready) begin
                m_phase = 0;
            end
            if (exp_g != 2'b00) begin
                s        = exp_g[1] ? 1 : 0;
                m_ctl    = f_ctl[s];
                m_rd     = alu_fn(f_ctl[s], f_a[s], f_b[s], f_im[s], f_isi[s]);
                m_ri     = f_ins[s];
                m_rs     = exp_g[1];
                m_rr     = ~exp_g[1];
                m_remain = (f_ctl[s][4] ? MULC : ALUL) + 1;
                m_phase  = 1;
            end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        req_valid       = 2'b00;
        res_ready       = 1'b0;
        req_alusignals  = '0;
        req_op1         = '0;
        req_op2         = '0;
        req_immx        = '0;
        req_isimmediate = '0;
        req_instr       = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_reset_mid();
        test_immediate();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
